paced_rr_arbiter: RTL
=====================

Name: paced_rr_arbiter

Overview:
Shares one paced ready/valid output channel between NUM_REQ ready/valid requesters.
- Arbitration is round-robin.
- After every accepted transfer, the channel is held idle for a runtime-programmable gap of cfg_wait cycles, using the same counter discipline as the existing pacer.
- Sits between several producers and one rate-limited consumer, e.g. a shared bus or serial link.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
DATA_WIDTH, 8, payload width
MAX_WAIT, 7, largest programmable gap; CNT_W = $clog2(MAX_WAIT+1)
BURST_LEN, 4, max back-to-back transfers per grant (used only with PACED_ARB_BURST_EN)

Ports:
clock_port  in  1  sole clock, rising edge
reset_port  in  1  asynchronous, active-high reset
in_data  in  NUM_REQ*DATA_WIDTH  requester payloads; requester i at bits [i*DATA_WIDTH +: DATA_WIDTH]
in_valid  in  NUM_REQ  per-requester valid
in_ready  out  NUM_REQ  per-requester ready; at most one bit high
out_data  out  DATA_WIDTH  payload of the granted requester
out_valid  out  1  output valid
out_ready  in  1  consumer ready
out_source  out  $clog2(NUM_REQ)  index of the granted requester; meaningful while out_valid=1
cfg_wait  in  CNT_W  gap cycles between transfers; sampled live every cycle

Behaviour:
Reset state (async assert):
- wait_cnt=0, rr_ptr=0, state=PACE, burst_cnt=0.
- Outputs: out_valid=0, in_ready=0, out_source=0.

Pacing:
- wait_done = (wait_cnt >= cfg_wait).
- wait_cnt increments by 1 each cycle while !wait_done and saturates at MAX_WAIT.
- On a transfer (out_valid & out_ready), wait_cnt<=0.
- With cfg_wait=N, transfers at T allow the next transfer no earlier than T+N+1.
- cfg_wait=0: back-to-back transfers every cycle.
- cfg_wait lowered below wait_cnt: wait_done asserts immediately.

Arbitration:
- pick = first i with in_valid[i]=1, searching from rr_ptr upward with wrap modulo NUM_REQ.
- On each transfer, rr_ptr <= granted index + 1, wrapping to 0 after NUM_REQ-1.

FSM states:
- PACE:
  - Outputs: out_valid=0, in_ready=0.
  - Exit: -> ARB when wait_done.
  - Reset-exit: if cfg_wait=0, PACE lasts exactly one cycle after reset.
- ARB:
  - Outputs: grant = pick, combinational from in_valid; out_valid = |in_valid; in_ready[grant] = out_ready.
  - Transfer -> PACE, or remain in ARB if the next wait_done is already true (cfg_wait=0).
  - out_valid & !out_ready -> HOLD, latching the grant into lock_idx.
- HOLD:
  - Grant frozen to lock_idx; out_valid = in_valid[lock_idx]; in_ready[lock_idx] = out_ready.
  - Transfer -> PACE.
  - in_valid[lock_idx] deasserted (producer protocol violation) -> ARB; no transfer occurs.

Datapath and latency:
- out_data = in_data slice of grant; out_source = grant; combinational.
- Zero-cycle latency input to output; no payload storage.

Simultaneous events:
- Transfer and reset edge: reset wins.
- Reset asserted mid-HOLD: grant lost, out_valid drops asynchronously to 0.

Optional Feature:
Macro PACED_ARB_BURST_EN.
- Defined:
  - After a transfer, if the same requester still has in_valid=1 and burst_cnt < BURST_LEN-1, stay in ARB with grant locked to that requester and skip pacing.
  - burst_cnt increments per transfer in the burst.
  - When the burst ends (valid dropped or length reached): burst_cnt<=0, rr_ptr advances, wait_cnt<=0, go to PACE.
- Undefined:
  - Every transfer is followed by PACE; burst_cnt and BURST_LEN logic are absent.

Decomposition:
Package paced_arb_pkg holds:
- state enum {PACE, ARB, HOLD};
- the CNT_W / index-width computation functions.

One sub-module, rr_pick:
- purely combinational rotate-priority picker;
- inputs: req vector, rr_ptr;
- outputs: idx, any.

Test Plan:
1. Reset, cfg_wait=2, in_valid=4'b0001, out_ready=1 -> first transfer on cycle 3 after reset release, then every 3rd cycle; out_source=0.
2. cfg_wait=0, in_valid=4'b1111, out_ready=1 -> one transfer per cycle, out_source sequence 0,1,2,3,0.
3. cfg_wait=1, in_valid=4'b0110, out_ready held 0 for 3 cycles -> out_source stays 1 and out_data stable; raising requester 0's valid does not change the grant; transfer occurs on ready.
4. In HOLD, drop in_valid[lock_idx] -> out_valid=0 next cycle with no transfer; the arbiter then re-picks.
5. Mid-HOLD async reset pulse -> out_valid=0 and in_ready=0 immediately; wait_cnt=0; next grant goes to requester 0 first.
6. With PACED_ARB_BURST_EN, BURST_LEN=4, cfg_wait=3, requester 2 always valid -> 4 consecutive transfers, then a 3-cycle gap, then grant rotates to the next valid requester.

Source files
------------

// File: rtl/paced_arb_pkg.sv
// Shared types and width helpers for the paced round-robin arbiter.
package paced_arb_pkg;

  typedef enum logic [1:0] {
    PACE,
    ARB,
    HOLD
  } arb_state_e;

  // Counter width able to hold 0..max_wait.
  function automatic int unsigned cnt_width(input int unsigned max_wait);
    return (max_wait > 0) ? $clog2(max_wait + 1) : 1;
  endfunction

  // Index width for n items, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/paced_rr_arbiter_rr_pick.sv
// Combinational rotate-priority picker: first set request at or above rr_ptr, wrapping.
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  logic [NUM_REQ-1:0] req_rot;
  logic [IDX_W-1:0]   offset;
  logic [IDX_W:0]     idx_sum;

  // Rotate so rr_ptr sits at bit 0, find the lowest set bit, rotate the index back.
  always_comb begin
    req_rot = NUM_REQ'({req, req} >> rr_ptr);
    offset  = '0;
    any     = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        offset = IDX_W'(i);
        any    = 1'b1;
      end
    end
    idx_sum = {1'b0, rr_ptr} + {1'b0, offset};
    if (idx_sum >= (IDX_W + 1)'(NUM_REQ)) begin
      idx_sum = idx_sum - (IDX_W + 1)'(NUM_REQ);
    end
    idx = idx_sum[IDX_W-1:0];
  end

endmodule

// File: rtl/paced_rr_arbiter.sv
// Round-robin arbiter feeding one paced ready/valid channel. After each transfer the
// channel idles for cfg_wait cycles. Optional burst mode: PACED_ARB_BURST_EN.
module paced_rr_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_WAIT   = 7,
  parameter int unsigned BURST_LEN  = 4
) (
  input  logic                            clock_port,
  input  logic                            reset_port,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   in_data,
  input  logic [NUM_REQ-1:0]              in_valid,
  output logic [NUM_REQ-1:0]              in_ready,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [$clog2(NUM_REQ)-1:0]      out_source,
  input  logic [$clog2(MAX_WAIT+1)-1:0]   cfg_wait
);

  import paced_arb_pkg::*;

  localparam int unsigned        CNT_W    = cnt_width(MAX_WAIT);
  localparam int unsigned        IDX_W    = idx_width(NUM_REQ);
  localparam logic [CNT_W-1:0]   CNT_MAX  = CNT_W'(MAX_WAIT);
  localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(NUM_REQ - 1);

  if (NUM_REQ < 2 || NUM_REQ > 16 || BURST_LEN < 1) begin : g_param_check
    $error("paced_rr_arbiter: unsupported parameter value");
  end

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] lock_idx_q, lock_idx_d;

  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic [IDX_W-1:0] grant;
  logic             locked;
  logic             xfer;
  logic             wait_done;
  logic             wait_done_nxt;
  logic             burst_cont;    // transfer that keeps the current burst going
  logic             pace_restart;  // grant released: restart pacing and rotate

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req    (in_valid),
    .rr_ptr (rr_ptr_q),
    .idx    (pick_idx),
    .any    (pick_any)
  );

`ifdef PACED_ARB_BURST_EN
  localparam int unsigned      BCNT_W     = idx_width(BURST_LEN);
  localparam logic [BCNT_W-1:0] BURST_LAST = BCNT_W'(BURST_LEN - 1);

  logic [BCNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic              burst_lock_q, burst_lock_d;
  logic              burst_drop;

  // Burst continues on a transfer below the length limit; ends on limit or dropped valid.
  always_comb begin
    burst_cont   = xfer && (burst_cnt_q < BURST_LAST);
    burst_drop   = burst_lock_q && (state_q != PACE) && !in_valid[lock_idx_q];
    pace_restart = (xfer && !burst_cont) || burst_drop;
    burst_cnt_d  = burst_cnt_q;
    burst_lock_d = burst_lock_q;
    if (pace_restart) begin
      burst_cnt_d  = '0;
      burst_lock_d = 1'b0;
    end else if (burst_cont) begin
      burst_cnt_d  = burst_cnt_q + BCNT_W'(1);
      burst_lock_d = 1'b1;
    end
  end

  // Burst bookkeeping registers.
  always_ff @(posedge clock_port or posedge reset_port) begin
    if (reset_port) begin
      burst_cnt_q  <= '0;
      burst_lock_q <= 1'b0;
    end else begin
      burst_cnt_q  <= burst_cnt_d;
      burst_lock_q <= burst_lock_d;
    end
  end

  assign locked = (state_q == HOLD) || burst_lock_q;
`else
  assign burst_cont   = 1'b0;
  assign pace_restart = xfer;
  assign locked       = (state_q == HOLD);
`endif

  // Grant selection, handshake outputs and payload mux (all combinational).
  always_comb begin
    grant = locked ? lock_idx_q : pick_idx;
    unique case (state_q)
      ARB:     out_valid = locked ? in_valid[lock_idx_q] : pick_any;
      HOLD:    out_valid = in_valid[lock_idx_q];
      default: out_valid = 1'b0;
    endcase
    in_ready = '0;
    out_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant == IDX_W'(i)) begin
        out_data    = in_data[i*DATA_WIDTH +: DATA_WIDTH];
        in_ready[i] = (state_q != PACE) && out_ready;
      end
    end
    out_source = (state_q == PACE) ? '0 : grant;
    xfer       = out_valid && out_ready;
  end

  // Gap counter; wait_done_nxt looks one cycle ahead so a gap of N gives period N+1.
  always_comb begin
    wait_done  = (wait_cnt_q >= cfg_wait);
    wait_cnt_d = wait_cnt_q;
    if (pace_restart) begin
      wait_cnt_d = '0;
    end else if (!wait_done && (wait_cnt_q != CNT_MAX)) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end
    wait_done_nxt = (wait_cnt_d >= cfg_wait);
  end

  // Next-state logic, grant lock and round-robin pointer update.
  always_comb begin
    state_d    = state_q;
    lock_idx_d = lock_idx_q;
    rr_ptr_d   = rr_ptr_q;
    if (pace_restart) begin
      rr_ptr_d = (grant == IDX_LAST) ? '0 : grant + IDX_W'(1);
    end
    unique case (state_q)
      PACE: begin
        if (wait_done_nxt) state_d = ARB;
      end
      ARB: begin
        if (pace_restart) begin
          state_d = wait_done_nxt ? ARB : PACE;
        end else if (burst_cont) begin
          lock_idx_d = grant;
        end else if (out_valid && !out_ready) begin
          state_d    = HOLD;
          lock_idx_d = grant;
        end
      end
      HOLD: begin
        if (pace_restart) begin
          state_d = wait_done_nxt ? ARB : PACE;
        end else if (burst_cont) begin
          state_d    = ARB;
          lock_idx_d = grant;
        end else if (!in_valid[lock_idx_q]) begin
          // Producer withdrew its request: no transfer, re-arbitrate.
          state_d = ARB;
        end
      end
      default: state_d = PACE;
    endcase
  end

  // State, counter and pointer registers.
  always_ff @(posedge clock_port or posedge reset_port) begin
    if (reset_port) begin
      state_q    <= PACE;
      wait_cnt_q <= '0;
      rr_ptr_q   <= '0;
      lock_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_idx_q <= lock_idx_d;
    end
  end

endmodule
